// File: rtl/posit_pkg.sv
// posit_pkg: shared posit datapath constants, FSM state encoding and scale saturation limits
package posit_pkg;
  localparam int ES      = 3;
  localparam int SCALE_W = 10;
  localparam int MANT_W  = 64;
  localparam logic signed [SCALE_W-1:0] SCALE_MAX = {1'b0, {(SCALE_W-1){1'b1}}};
  localparam logic signed [SCALE_W-1:0] SCALE_MIN = {1'b1, {(SCALE_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, FINAL} state_t;
endpackage

// File: rtl/adjustment_scale_split.sv
// scale_split: splits a signed scale into sign, regime magnitude |floor(scale/8)| and exponent scale mod 8
// Ports: scale (in, signed) -> exp_sign, adj_regime (saturates at 63), adj_exp
module scale_split
  import posit_pkg::*;
(
  input  logic signed [SCALE_W-1:0] scale,
  output logic                      exp_sign,
  output logic [5:0]                adj_regime,
  output logic [ES-1:0]             adj_exp
);
  logic signed [SCALE_W-ES-1:0] k;
  logic [SCALE_W-ES-1:0] k_mag;
  assign k          = scale[SCALE_W-1:ES];
  assign k_mag      = k[SCALE_W-ES-1] ? -k : k;
  // only k = -64 produces magnitude 64, which does not fit the 6-bit regime
  assign adj_regime = k_mag[SCALE_W-ES-1] ? 6'd63 : k_mag[5:0];
  assign adj_exp    = scale[ES-1:0];
  assign exp_sign   = scale[SCALE_W-1];
endmodule

// File: rtl/adjustment.sv
// adjustment: posit multiplier normalization stage, moves the hidden 1 to bit 62 and corrects/splits the scale
// Ports: clk, reset (sync, active-low), start, scale_in, mant_prod in;
//        scale_out, mant_adj, shift_amt, done, adj_exp, adj_regime, exp_sign out.
// Build option ADJ_STICKY_EN: keep the bit dropped by the right shift as a sticky bit in bit 0.
module adjustment
  import posit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [SCALE_W-1:0] scale_in,
  input  logic [MANT_W-1:0]         mant_prod,
  output logic signed [SCALE_W-1:0] scale_out,
  output logic [MANT_W-1:0]         mant_adj,
  output logic [MANT_W-1:0]         shift_amt,
  output logic                      done,
  output logic [ES-1:0]             adj_exp,
  output logic [5:0]                adj_regime,
  output logic                      exp_sign
);
  state_t state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d, mant_adj_q, mant_adj_d, mant_rsh;
  logic signed [SCALE_W-1:0] scale_q, scale_d, scale_out_q, scale_out_d, scale_inc, scale_dec;
  logic [6:0] cnt_q, cnt_d, shift_q, shift_d;
  logic [5:0] regime_q, regime_d, sp_regime;
  logic [ES-1:0] exp_q, exp_d, sp_exp;
  logic sign_q, sign_d, sp_sign, done_q, done_d;
  scale_split u_split (.scale(scale_q), .exp_sign(sp_sign), .adj_regime(sp_regime), .adj_exp(sp_exp));
  assign scale_inc = scale_q == SCALE_MAX ? scale_q : scale_q + SCALE_W'(1);
  assign scale_dec = scale_q == SCALE_MIN ? scale_q : scale_q - SCALE_W'(1);
`ifdef ADJ_STICKY_EN
  assign mant_rsh = (mant_q >> 1) | {{(MANT_W-1){1'b0}}, mant_q[0]};
`else
  assign mant_rsh = mant_q >> 1;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      scale_q     <= '0;
      cnt_q       <= '0;
      mant_adj_q  <= '0;
      scale_out_q <= '0;
      shift_q     <= '0;
      regime_q    <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      scale_q     <= scale_d;
      cnt_q       <= cnt_d;
      mant_adj_q  <= mant_adj_d;
      scale_out_q <= scale_out_d;
      shift_q     <= shift_d;
      regime_q    <= regime_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      done_q      <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    scale_d = scale_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        mant_d  = mant_prod;
        scale_d = scale_in;
        cnt_d   = '0;
        state_d = CHECK;
      end
      CHECK: if (mant_q[MANT_W-1]) begin
        mant_d  = mant_rsh;
        scale_d = scale_inc;
        cnt_d   = 7'd1;
        state_d = FINAL;
      end else begin
        state_d = (mant_q[MANT_W-2] || mant_q == '0) ? FINAL : SHIFT;
      end
      SHIFT: begin
        mant_d  = mant_q << 1;
        scale_d = scale_dec;
        cnt_d   = cnt_q + 7'd1;
        // leave as soon as the bit moving into position 62 is the leading one
        state_d = mant_q[MANT_W-3] ? FINAL : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    done_d      = state_q == FINAL;
    mant_adj_d  = done_d ? mant_q : mant_adj_q;
    scale_out_d = done_d ? scale_q : scale_out_q;
    shift_d     = done_d ? cnt_q : shift_q;
    regime_d    = done_d ? sp_regime : regime_q;
    exp_d       = done_d ? sp_exp : exp_q;
    sign_d      = done_d ? sp_sign : sign_q;
  end
  assign mant_adj   = mant_adj_q;
  assign scale_out  = scale_out_q;
  assign shift_amt  = {{(MANT_W-7){1'b0}}, shift_q};
  assign adj_regime = regime_q;
  assign adj_exp    = exp_q;
  assign exp_sign   = sign_q;
  assign done       = done_q;
endmodule

// File: tb/tb_adjustment.sv
// tb_adjustment: directed scoreboard bench for the adjustment normalization stage
module tb_adjustment;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic signed [9:0] scale_in = '0, scale_out;
  logic [63:0] mant_prod = '0, mant_adj, shift_amt;
  logic done, exp_sign;
  logic [2:0] adj_exp;
  logic [5:0] adj_regime;
  int n_vec = 0, n_cmp = 0, n_err = 0;
  typedef struct {
    logic [63:0] mant;
    logic signed [9:0] scale;
    logic [63:0] shift;
    logic [5:0] regime;
    logic [2:0] e;
    logic sign;
    int lat;
  } exp_t;
  exp_t sb[$];
  adjustment dut (.clk(clk), .reset(reset), .start(start), .scale_in(scale_in), .mant_prod(mant_prod),
    .scale_out(scale_out), .mant_adj(mant_adj), .shift_amt(shift_amt), .done(done),
    .adj_exp(adj_exp), .adj_regime(adj_regime), .exp_sign(exp_sign));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  function automatic exp_t model(input int s, input logic [63:0] m);
    exp_t r;
    int p = -1, k;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    r.mant = m;
    r.shift = 0;
    if (p == 63) begin
      r.mant = m >> 1;
`ifdef ADJ_STICKY_EN
      r.mant[0] = r.mant[0] | m[0];
`endif
      r.shift = 1;
      s = (s + 1 > 511) ? 511 : s + 1;
    end else if (p >= 0 && p < 62) begin
      r.shift = 64'(62 - p);
      r.mant = m << (62 - p);
      s = (s - (62 - p) < -512) ? -512 : s - (62 - p);
    end
    k = (s >= 0) ? s / 8 : -((-s + 7) / 8);
    r.scale = 10'(s);
    r.e = 3'(s - 8 * k);
    r.regime = (k < 0) ? ((-k > 63) ? 6'd63 : 6'(-k)) : 6'(k);
    r.sign = s < 0;
    r.lat = 3 + int'(r.shift > 1 ? r.shift : 0) + ((p >= 0 && p < 62 && r.shift == 1) ? 1 : 0);
    return r;
  endfunction
  // drive one request, push its expectation, then wait for done and compare
  task automatic run(input int s, input logic [63:0] m);
    exp_t e;
    int cyc;
    scale_in = 10'(s);
    mant_prod = m;
    start = 1'b1;
    sb.push_back(model(s, m));
    n_vec++;
    @(posedge clk);
    #1 start = 1'b0;
    scale_in = 10'sd77;
    mant_prod = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
      // a start raised while busy must be ignored
      start = (cyc == 2);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("mant_adj", mant_adj, e.mant);
    chk("scale_out", 64'(scale_out), 64'(e.scale));
    chk("shift_amt", shift_amt, e.shift);
    chk("adj_regime", 64'(adj_regime), 64'(e.regime));
    chk("adj_exp", 64'(adj_exp), 64'(e.e));
    chk("exp_sign", 64'(exp_sign), 64'(e.sign));
    @(posedge clk);
    #1 chk("done_pulse", 64'(done), 64'd0);
    chk("held_mant", mant_adj, e.mant);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("rst_done", 64'(done), 64'd0);
    chk("rst_mant", mant_adj, 64'd0);
    chk("rst_scale", 64'(scale_out), 64'd0);
    chk("rst_misc", {shift_amt[60:0], adj_regime, adj_exp}, 64'd0);
    reset = 1'b1;
    run(100, 64'hC000_0000_0000_0000);
    chk("plan1_mant", mant_adj, 64'h6000_0000_0000_0000);
    chk("plan1_split", {58'd0, adj_regime}, 64'd12);
    run(100, 64'h8000_0000_0000_0000);
    run(100, 64'h4000_0000_0000_0000);
    chk("plan3_exp", 64'(adj_exp), 64'd4);
    run(100, 64'h00F0_0000_0000_0000);
    chk("plan4_mant", mant_adj, 64'h7800_0000_0000_0000);
    chk("plan4_scale", 64'(scale_out), 64'(10'sd93));
    run(-3, 64'h4000_0000_0000_0000);
    chk("neg_regime", 64'(adj_regime), 64'd1);
    run(-512, 64'h0000_0000_0000_0001);
    chk("sat_lo_regime", 64'(adj_regime), 64'd63);
    chk("sat_lo_shift", shift_amt, 64'd62);
    run(511, 64'hC000_0000_0000_0000);
    chk("sat_hi_scale", 64'(scale_out), 64'(10'sd511));
    run(37, 64'h0);
    chk("zero_mant", mant_adj, 64'd0);
    run(5, 64'hC000_0000_0000_0001);
`ifdef ADJ_STICKY_EN
    chk("sticky", mant_adj, 64'h6000_0000_0000_0001);
`else
    chk("sticky", mant_adj, 64'h6000_0000_0000_0000);
`endif
    run(-8, 64'h3FFF_FFFF_FFFF_FFFF);
    run(-9, 64'h0000_0001_2345_6789);
    for (int i = 0; i < 4; i++) run(int'($urandom_range(0, 1023)) - 512, {$urandom, $urandom});
    scale_in = 10'sd50;
    mant_prod = 64'h1;
    start = 1'b1;
    n_vec++;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    chk("midrst_mant", mant_adj, 64'd0);
    chk("midrst_scale", 64'(scale_out), 64'd0);
    chk("midrst_split", {shift_amt[60:0], adj_regime, adj_exp}, 64'd0);
    begin
      int seen = 0;
      repeat (80) begin
        @(posedge clk);
        #1 seen |= int'(done);
      end
      chk("midrst_nodone", 64'(seen), 64'd0);
    end
    run(100, 64'h00F0_0000_0000_0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adjustment.md
Name: adjustment

Overview:
- Normalization stage of the posit multiplier datapath (es = 3).
- Takes the raw 64-bit mantissa product (Q2.62, integer bits [63:62]) and the summed scale from the multiply stage.
- Renormalizes the product so the hidden 1 sits at bit 62 and corrects the scale.
- Splits the corrected scale into regime magnitude, exponent and sign for the downstream posit encoder.

Parameters:
- ES, 3, exponent field width; fixes adj_exp width and regime split (scale = k*8 + e).
- SCALE_W, 10, signed two's-complement scale width.
- MANT_W, 64, mantissa product width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request; inputs sampled on the same edge.
- scale_in  input  10  signed scale of the product.
- mant_prod  input  64  unsigned Q2.62 mantissa product.
- scale_out  output  10  signed corrected scale.
- mant_adj  output  64  normalized mantissa, hidden 1 at bit 62 (0 if input was 0).
- shift_amt  output  64  unsigned magnitude of the normalization shift, in bit positions; bits [63:7] always 0.
- done  output  1  one-cycle pulse: outputs valid.
- adj_exp  output  3  scale_out[2:0] (floor-mod-8 exponent).
- adj_regime  output  6  |k|, where k = scale_out >>> 3 (arithmetic); saturates at 63.
- exp_sign  output  1  scale_out[9] (1 = negative scale).

Behaviour:
- Reset (reset==0 at a rising edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset has priority over everything, including mid-operation; any in-flight result is discarded and no done is issued.
- FSM states: IDLE, CHECK, SHIFT, FINAL.
- IDLE:
  - On start==1, latch mant_prod into mant_work and scale_in into scale_work, clear the shift counter, go to CHECK.
  - Previous outputs are held until the next FINAL.
- CHECK (one cycle):
  - mant_work[63]==1 (patterns 11/10): mant_work >>= 1, scale_work += 1, count = 1, go to FINAL.
  - [63:62]==01: no change, count = 0, go to FINAL.
  - mant_work==0: no change, count = 0, go to FINAL; outputs mant_adj = 0, scale_out = scale_in.
  - Otherwise: go to SHIFT.
- SHIFT: each cycle shift mant_work left 1, scale_work -= 1, count += 1. Go to FINAL in the cycle in which the shifted value has bit 62 set.
- FINAL (one cycle):
  - Register mant_adj, scale_out, shift_amt, adj_exp, adj_regime, exp_sign.
  - Pulse done=1 for exactly this cycle, then go to IDLE.
- Latency:
  - done is high 3 cycles after the start edge when no left shift is needed.
  - With n left shifts it is 3+n cycles; the maximum is n = 62.
- start is ignored outside IDLE; there is no queueing.
- Scale arithmetic saturates at +511 and -512; there is no wrap.
- Regime split:
  - k = floor(scale_out/8); e = scale_out - 8k, always in 0..7.
  - adj_regime = k if k >= 0, else -k.
  - k = -64 saturates adj_regime to 63.

Optional Feature:
- Macro: ADJ_STICKY_EN.
- Defined: on the CHECK right shift, the discarded bit 0 is ORed into the new bit 0 (sticky, for rounding downstream).
- Undefined: the discarded bit is dropped (truncation).
- Left shifts are unaffected in both builds.

Decomposition:
- Shared package posit_pkg holds:
  - the ES, SCALE_W and MANT_W constants;
  - the FSM state enum (IDLE/CHECK/SHIFT/FINAL);
  - the saturation limits SCALE_MAX = 511 and SCALE_MIN = -512.
- One natural sub-module, scale_split: combinational scale -> {exp_sign, adj_regime, adj_exp}, reusable by the encoder.
- Shift loop and FSM remain in adjustment.

Test Plan:
- scale_in=100, mant_prod=0xC000000000000000 -> mant_adj=0x6000000000000000, scale_out=101, shift_amt=1, exp_sign=0, adj_regime=12, adj_exp=5, done at +3 cycles.
- scale_in=100, mant_prod=0x8000000000000000 -> mant_adj=0x4000000000000000, scale_out=101, shift_amt=1, regime 12, exp 5.
- scale_in=100, mant_prod=0x4000000000000000 -> mant_adj unchanged, scale_out=100, shift_amt=0, regime 12, exp 4.
- scale_in=100, mant_prod=0x00F0000000000000 -> mant_adj=0x7800000000000000, scale_out=93, shift_amt=7, regime 11, exp 5, done at +10 cycles.
- scale_in=-3, mant_prod=0x4000000000000000 -> scale_out=-3, exp_sign=1, adj_regime=1, adj_exp=5; scale_in=-512 with 0x0000000000000001 -> scale_out saturates at -512, mant_adj=0x4000000000000000, shift_amt=62, adj_regime=63.
- Reset low during SHIFT -> no done, outputs 0; mant_prod=0 -> mant_adj=0, shift_amt=0; with ADJ_STICKY_EN, 0xC000000000000001 -> mant_adj=0x6000000000000001 (without it: 0x6000000000000000).
